// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives
// the datapath muxes, register file, memories and the PC/IR load enables.
// Memory accesses wait on mem_ready with a bounded timeout. Illegal encodings
// and timeouts trap into a sticky ERR state that only reset leaves.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instruction[31:0]          IR contents (valid from DECODE onward)
//   zero                       ALU zero flag, used by branches in EXEC
//   mem_ready                  memory completes the current access this cycle
//   ALUOp[ALUOP_W-1:0]         ALU operation code (4-bit codes, zero-extended)
//   PCWrite, IRWrite           PC / IR load enables
//   jumpSrc, PCSrc             PC source select: jump target / branch target
//   RegWrite, MemWrite, MemtoReg, MemRead, RegDst   datapath controls
//   instr_done                 pulse on the last cycle of each instruction
//   error, error_code[1:0]     sticky trap flag; 1 = illegal, 2 = mem timeout
//   state[2:0]                 debug state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERR=5
module multicycle_control #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               jumpSrc,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               MemRead,
    output logic               RegDst,
    output logic               instr_done,
    output logic               error,
    output logic [1:0]         error_code,
    output logic [2:0]         state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Value the wait counter holds during the last waiting cycle allowed.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             error_q, error_d;
    logic [1:0]       code_q, code_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r, is_lw, is_sw, is_beq, is_bne, is_j;
    logic       legal;
    logic [3:0] alu_code;
    logic       unused_fields;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign is_r   = (opcode == OP_RTYPE);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_j   = (opcode == OP_J);
    // Register and immediate fields belong to the datapath, not to control.
    assign unused_fields = ^instruction[25:6];

    // Instruction decode: legality and fixed ALU operation code.
    always_comb begin
        legal    = 1'b0;
        alu_code = 4'd0;
        case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    6'b100000: alu_code = 4'd4;   // add
                    6'b100100: alu_code = 4'd1;   // and
                    6'b011010: alu_code = 4'd7;   // div
                    6'b100101: alu_code = 4'd0;   // or
                    6'b100110: alu_code = 4'd2;   // xor
                    6'b100111: alu_code = 4'd3;   // nor
                    6'b100010: alu_code = 4'd5;   // sub
                    6'b101010: alu_code = 4'd6;   // slt
                    6'b011000: alu_code = 4'd8;   // mult
                    6'b000011: alu_code = 4'd9;   // sra
                    6'b000010: alu_code = 4'd10;  // srl
                    6'b000000: alu_code = 4'd11;  // sll
                    default:   legal    = 1'b0;
                endcase
            end
            OP_SW:   begin legal = 1'b1; alu_code = 4'd12; end
            OP_LW:   begin legal = 1'b1; alu_code = 4'd13; end
            OP_BEQ:  begin legal = 1'b1; alu_code = 4'd14; end
            OP_BNE:  begin legal = 1'b1; alu_code = 4'd14; end
            OP_J:    begin legal = 1'b1; alu_code = 4'd15; end
            default: ;
        endcase
    end

    // Next state, wait counter, trap capture and datapath controls.
    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        code_d     = code_q;
        wait_d     = '0;
        ALUOp      = '0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        jumpSrc    = 1'b0;
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        MemRead    = 1'b0;
        RegDst     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    code_d  = ERR_ILLEGAL;
                end
            end
            S_EXEC: begin
                ALUOp = ALUOP_W'(alu_code);
                if (is_r) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    PCSrc      = zero;
                    PCWrite    = zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_bne) begin
                    PCSrc      = !zero;
                    PCWrite    = !zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_j) begin
                    jumpSrc    = 1'b1;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    // IR changed under us after DECODE; treat as illegal.
                    state_d = S_ERR;
                    error_d = 1'b1;
                    code_d  = ERR_ILLEGAL;
                end
            end
            S_MEM: begin
                ALUOp  = ALUOP_W'(alu_code);
                RegDst = 1'b1;
                if (is_lw) MemRead  = 1'b1;
                else       MemWrite = 1'b1;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                if (is_lw) begin
                    RegDst   = 1'b1;
                    MemtoReg = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_ERR:   ;
            default: state_d = S_FETCH;
        endcase

        // Count only cycles that stay in FETCH/MEM waiting; any transition or
        // mem_ready clears the counter.
        if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + CNT_W'(1);
        end

        // Reset silences the datapath immediately, aborting any access in flight.
        if (reset) begin
            ALUOp      = '0;
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            jumpSrc    = 1'b0;
            PCSrc      = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            MemRead    = 1'b0;
            RegDst     = 1'b0;
            instr_done = 1'b0;
        end
    end

    // State, wait counter and sticky trap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    // Registered status, forced to the idle view while reset is held.
    assign state      = reset ? 3'd0 : 3'(state_q);
    assign error      = error_q & !reset;
    assign error_code = reset ? ERR_NONE : code_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS control decoder. A state machine sequences every instruction through fetch, decode, execute, memory and write-back. It drives the same datapath control lines plus PC/IR write enables. Memory accesses stall on a ready handshake with a bounded timeout, and illegal encodings or timeouts trap into a sticky error state. It sits between the instruction register / ALU `zero` flag and the toy MIPS datapath muxes, register file and memories.

## Interface
- `ALUOP_W`, 4: width of `ALUOp`; must be ≥4. Codes are zero-extended.
- `TIMEOUT`, 15: maximum cycles spent waiting for `mem_ready` in FETCH or MEM before trapping; must be ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instruction`  in  32  current IR contents; valid from DECODE onward.
- `zero`  in  1  ALU zero flag; sampled in EXEC.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `ALUOp`  out  ALUOP_W  ALU operation code.
- `PCWrite`  out  1  PC load enable.
- `IRWrite`  out  1  IR load enable.
- `jumpSrc`  out  1  PC source is the jump target.
- `PCSrc`  out  1  PC source is the branch target.
- `RegWrite`, `MemWrite`, `MemtoReg`, `MemRead`, `RegDst`  out  1 each  datapath controls, same meaning as in the single-cycle decoder.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `error`  out  1  sticky trap flag.
- `error_code`  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout.
- `state`  out  3  debug state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5.

## Operation
- Decoded instruction set and fixed ALUOp codes.
  - R-type (opcode 0), by funct: add 100000→4, and 100100→1, div 011010→7, or 100101→0, xor 100110→2, nor 100111→3, sub 100010→5, slt 101010→6, mult 011000→8, sra 000011→9, srl 000010→10, sll 000000→11.
  - Other opcodes: sw 101011→12, lw 100011→13, beq 000100→14, bne 000101→14, j 000010→15.
- FETCH:
  - MemRead=1.
  - On `mem_ready`: IRWrite=1, PCWrite=1 (PC+4 path, PCSrc=jumpSrc=0), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - All controls 0.
  - A legal encoding goes to EXEC.
  - Any other opcode, or an unlisted funct, goes to ERR with code 1.
- EXEC:
  - ALUOp is driven for the instruction.
  - R-type goes to WB.
  - lw and sw go to MEM.
  - beq: PCSrc=PCWrite=`zero`.
  - bne: PCSrc=PCWrite=!`zero`.
  - j: jumpSrc=PCWrite=1.
  - Branches and jumps pulse `instr_done` and go to FETCH.
- MEM (ALUOp held at 12/13, RegDst=1):
  - lw: MemRead=1; on `mem_ready` go to WB.
  - sw: MemWrite=1; on `mem_ready` pulse `instr_done` and go to FETCH.
- WB:
  - RegWrite=1 and `instr_done`=1, then go to FETCH.
  - R-type: RegDst=0, MemtoReg=0.
  - lw: RegDst=1, MemtoReg=1.
- ERR:
  - All datapath controls 0; `error`=1.
  - The state is held until `reset`.
- Wait counter:
  - Clears on entry to FETCH or MEM and on `mem_ready`.
  - Increments each cycle spent waiting.
  - Reaching TIMEOUT without `mem_ready` goes to ERR with code 2.
  - If `mem_ready` arrives in the same cycle the counter expires, `mem_ready` wins.
  - Counter width is $clog2(TIMEOUT+1).
- `mem_ready` is ignored outside FETCH and MEM.
- Outputs not listed for a state are 0. ALUOp is 0 in FETCH, DECODE and ERR.

## Timing
- While `reset` is high:
  - All outputs are 0, including `error`, `error_code` and `instr_done`.
  - State is FETCH; the wait counter is 0.
- The first cycle after release is FETCH with MemRead=1.
- Outputs are combinational from the registered state, `instruction` and `zero`. There are no registered outputs except `error`, `error_code` and `state`.
- Minimum latency with `mem_ready` tied high:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j: 3 cycles.
- Each cycle `mem_ready` is low adds one cycle.
- Reset asserted mid-instruction (including MEM with MemWrite high):
  - The instruction is aborted on that edge.
  - No `instr_done` pulse.
  - Restart at FETCH.
- `error` rises on the edge entering ERR and stays high until `reset`.

## Test plan
- Reset, then R-type add (funct 100000), `mem_ready`=1:
  - `state` goes 0,1,2,4,0.
  - ALUOp=4 in EXEC.
  - RegWrite=1 and RegDst=0 only in WB.
  - `instr_done` high exactly in cycle 4.
- lw with `mem_ready` low for 3 MEM cycles:
  - MEM lasts 4 cycles with MemRead=1 and ALUOp=13.
  - Then WB with RegWrite=MemtoReg=RegDst=1.
  - Total latency 8 cycles.
- Branches (beq/bne):
  - beq with `zero`=1: PCSrc=PCWrite=1 in EXEC.
  - beq with `zero`=0: PCWrite=0.
  - bne with `zero`=0: PCSrc=1.
  - Each is 3 cycles.
- j (opcode 000010): jumpSrc=PCWrite=1 and ALUOp=15 in EXEC, then back to FETCH.
- Traps:
  - Opcode 111111 gives ERR, `error`=1, `error_code`=1, held for 20 cycles.
  - `reset` clears it.
- Timeout:
  - sw with `mem_ready` stuck low: ERR with code 2 after exactly TIMEOUT waiting cycles.
  - Repeat with `mem_ready` high on the expiry cycle: completes normally with `instr_done`.
- Reset during MEM of sw: all outputs 0 next cycle, `state`=0, and no `instr_done` pulse.
